display_counter: RTL and testbench
==================================

// Module: display_counter
//
// PURPOSE
//   Parametrised, prescaled, multi-digit up/down counter for UPduino 12 MHz designs.
//   Divides CLK down to a TICK_HZ strobe and steps a DIGITS-wide BCD or hex count on
//   each strobe. Supports load, direction and enable.
//   Optionally multiplexes the count onto the 7-segment display (SEG/COMM).
//   Sits between top-level board pins and user logic; replaces free-running LED counters.
//
// PARAMETERS
//   CLK_HZ   12_000_000  input clock frequency
//   TICK_HZ  4           count rate; DIV = CLK_HZ/TICK_HZ (integer), DIV >= 2 required
//   DIGITS   4           number of 4-bit digits in COUNT (1..8)
//   BCD      1           1: digits 0..9 (decimal); 0: digits 0..F (hex)
//   SCAN_HZ  1000        per-digit refresh rate, SCAN_DIV = CLK_HZ/(SCAN_HZ*DIGITS) >= 1
//                        (used only with DISPLAY_COUNTER_SCAN_EN)
//
// PORTS
//   CLK       in   1         system clock; all state on rising edge
//   RST       in   1         asynchronous, active-high reset
//   EN        in   1         1: prescaler runs; 0: prescaler and count frozen
//   UP        in   1         1: count up; 0: count down (sampled at each tick)
//   LOAD      in   1         synchronous load of LOAD_VAL
//   LOAD_VAL  in   4*DIGITS  value loaded; digit i = LOAD_VAL[4i+3:4i]
//   COUNT     out  4*DIGITS  current count; digit 0 least significant
//   TICK      out  1         one-cycle pulse on each count step
//   TC        out  1         one-cycle pulse when the step wrapped (terminal count)
//   SEG       out  7         {g,f,e,d,c,b,a}, active high (SCAN_EN only)
//   COMM      out  DIGITS    digit commons, active low, one-hot (SCAN_EN only)
//
// BEHAVIOUR
//   - Reset (async, immediate, also mid-operation): COUNT=0, prescaler=0, TICK=0, TC=0,
//     scan index=0, SEG=0, COMM=all 1s.
//   - Prescaler counts 0..DIV-1 while EN=1. At the edge where it equals DIV-1:
//     - it wraps to 0;
//     - COUNT takes its next value and TICK<=1, both visible in the same cycle.
//     TICK is 0 in all other cycles. EN=0 holds prescaler, COUNT; TICK=TC=0.
//   - Step: digit 0 incremented/decremented; carry/borrow ripples through all digits in
//     one cycle. Digit max = 9 (BCD=1) or F (BCD=0). Up: max->0 with carry; down: 0->max
//     with borrow.
//   - Wrap: all-max stepping up -> all zero; all-zero stepping down -> all max.
//     TC<=1 in that same cycle, else 0.
//   - LOAD has priority over EN and tick; independent of EN. At the edge:
//     - COUNT<=LOAD_VAL; prescaler<=0; TICK<=0; TC<=0.
//     - BCD=1: any loaded digit >9 clamps to 9.
//     - Next TICK follows DIV cycles after LOAD deasserts.
//   - UP change mid-interval affects only the next step; no glitch on COUNT.
//
// CONFIGURATION
//   DISPLAY_COUNTER_SCAN_EN defined:
//     - SEG/COMM ports exist; scan prescaler pulses every SCAN_DIV cycles and advances
//       the index 0..DIGITS-1 (wrapping).
//     - COMM[index]=0, others 1; SEG = 7-seg decode of COUNT digit[index]; hex A-F shown.
//     - Both SEG and COMM are registered and update on the same edge.
//     - Scan runs regardless of EN/LOAD.
//   Not defined: SEG/COMM ports and scan logic absent; remaining behaviour identical.
//
// STRUCTURE
//   display_pkg: SEG_* 7-bit constants for glyphs 0-F, DIGIT_MAX_BCD/DIGIT_MAX_HEX,
//   seg_decode function.
//   Sub-module count_digit: one 4-bit digit with inputs {step, up, max}; outputs
//   {value, carry_out}; DIGITS instances chained; load handled in parent.
//
// TESTING  (CLK_HZ=8, TICK_HZ=2 -> DIV=4; DIGITS=4; SCAN_HZ=1 -> SCAN_DIV=2)
//   1. RST=1 mid-count -> COUNT=0x0000, TICK=0, TC=0, COMM=4'b1111 immediately.
//   2. EN=1, UP=1 from reset -> TICK high on 4th edge only, COUNT=0x0001 there;
//      EN=0 for 3 cycles mid-interval -> TICK delayed by exactly 3 cycles.
//   3. BCD=1: LOAD 0x0009, tick -> 0x0010, TC=0;
//      LOAD 0x9999, tick -> 0x0000, TC=1 for one cycle.
//   4. UP=0: LOAD 0x0000, tick -> 0x9999 (BCD=1) / 0xFFFF (BCD=0), TC=1;
//      LOAD 0x0100 -> 0x0099 (BCD=1).
//   5. LOAD 0x00A5 (BCD=1) on the tick edge -> COUNT=0x0095, TICK=0;
//      next TICK 4 cycles after LOAD falls.
//   6. SCAN_EN, COUNT=0x1234 -> COMM cycles 1110,1101,1011,0111 every 2 cycles;
//      SEG=1100110 while COMM=1110 (digit 4).

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for display_counter: 7-segment glyphs {g,f,e,d,c,b,a}
// (active high), per-digit maxima and the hex glyph decoder.
package display_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [3:0] DIGIT_MAX_BCD = 4'd9;
  localparam logic [3:0] DIGIT_MAX_HEX = 4'hF;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/count_digit.sv
// One 4-bit counter digit: combinational next value and carry/borrow.
// The digit register and load path live in the parent.
module count_digit (
  input  logic [3:0] cur,
  input  logic       step,
  input  logic       up,
  input  logic [3:0] max,
  output logic [3:0] value,
  output logic       carry_out
);

  always_comb begin
    value     = cur;
    carry_out = 1'b0;
    if (step) begin
      if (up) begin
        if (cur >= max) begin
          value     = '0;
          carry_out = 1'b1;
        end else begin
          value = cur + 4'd1;
        end
      end else if (cur == '0) begin
        value     = max;
        carry_out = 1'b1;
      end else begin
        value = cur - 4'd1;
      end
    end
  end

endmodule

// File: rtl/display_counter.sv
// Prescaled multi-digit BCD/hex up/down counter with load.
// Define DISPLAY_COUNTER_SCAN_EN to add the multiplexed 7-segment outputs seg/comm.
module display_counter
  import display_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 12_000_000,
  parameter int unsigned TICK_HZ = 4,
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned BCD     = 1,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  tc
`ifdef DISPLAY_COUNTER_SCAN_EN
  ,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     comm
`endif
);

  localparam int unsigned DIV      = CLK_HZ / TICK_HZ;
  localparam int unsigned PW       = $clog2(DIV);
  localparam int unsigned SCAN_DIV = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam logic [3:0]  MAX      = (BCD != 0) ? DIGIT_MAX_BCD : DIGIT_MAX_HEX;

  if (DIV < 2 || SCAN_DIV < 1 || DIGITS < 1 || DIGITS > 8) begin : g_bad_params
    $error("display_counter: invalid parameter combination");
  end

  logic [PW-1:0]       presc;
  logic [4*DIGITS-1:0] count_next;
  logic [4*DIGITS-1:0] load_clamped;
  logic [DIGITS:0]     step_chain;
  logic                at_end;

  assign at_end        = (presc == PW'(DIV - 1));
  assign step_chain[0] = 1'b1;

  // Chain always computes the stepped value; it is only committed on a tick.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    count_digit u_digit (
      .cur      (count[4*i +: 4]),
      .step     (step_chain[i]),
      .up       (up),
      .max      (MAX),
      .value    (count_next[4*i +: 4]),
      .carry_out(step_chain[i+1])
    );
  end

  always_comb begin
    load_clamped = load_val;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (BCD != 0 && load_val[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      presc <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      presc <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (en && at_end) begin
      count <= count_next;
      presc <= '0;
      tick  <= 1'b1;
      tc    <= step_chain[DIGITS];
    end else begin
      if (en) presc <= presc + PW'(1);
      tick <= 1'b0;
      tc   <= 1'b0;
    end
  end

`ifdef DISPLAY_COUNTER_SCAN_EN
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic [3:0]    cur_digit;

  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) cur_digit = count[4*i +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg      <= '0;
      comm     <= '1;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      seg  <= seg_decode(cur_digit);
      comm <= ~(DIGITS'(1) << idx);
    end
  end
`endif

endmodule

// File: tb/tb_display_counter.sv
// Bench for display_counter: one BCD and one hex instance share the stimulus.
module tb_display_counter;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [15:0] load_val;
  logic [15:0] count_b, count_h;
  logic        tick_b, tick_h, tc_b, tc_h;
`ifdef DISPLAY_COUNTER_SCAN_EN
  logic [6:0]  seg_b, seg_h;
  logic [3:0]  comm_b, comm_h;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  display_counter #(.CLK_HZ(8), .TICK_HZ(2), .DIGITS(4), .BCD(1), .SCAN_HZ(1)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_b), .tick(tick_b), .tc(tc_b)
`ifdef DISPLAY_COUNTER_SCAN_EN
    , .seg(seg_b), .comm(comm_b)
`endif
  );

  display_counter #(.CLK_HZ(8), .TICK_HZ(2), .DIGITS(4), .BCD(0), .SCAN_HZ(1)) dut_hex (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_h), .tick(tick_h), .tc(tc_h)
`ifdef DISPLAY_COUNTER_SCAN_EN
    , .seg(seg_h), .comm(comm_h)
`endif
  );

  typedef struct {
    logic        up;
    logic [15:0] lv;
    logic [15:0] ld_b, ld_h;
    logic [15:0] nx_b, nx_h;
    logic        tc_b, tc_h;
  } vec_t;

  typedef struct {
    logic [15:0] nx_b, nx_h;
    logic        tc_b, tc_h;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Counts negedges until tick_b is seen (bounded); returns 0 on timeout.
  task automatic wait_tick(input int unsigned limit, output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_b && n < limit);
    if (!tick_b) n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    exp_t e;

    vecs[0] = '{1'b1, 16'h0009, 16'h0009, 16'h0009, 16'h0010, 16'h000A, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h9999, 16'h9999, 16'h9999, 16'h0000, 16'h999A, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h9999, 16'hFFFF, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0099, 16'h00FF, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h00A5, 16'h0095, 16'h00A5, 16'h0096, 16'h00A6, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'hFFFF, 16'h9999, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 16'h1230, 16'h1230, 16'h1230, 16'h1229, 16'h122F, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 16'h0199, 16'h0199, 16'h0199, 16'h0200, 16'h019A, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    #2;
    chk("reset_count", {16'h0, count_b}, 32'h0);
    chk("reset_tick", {31'h0, tick_b}, 32'h0);
    chk("reset_tc", {31'h0, tc_b}, 32'h0);
`ifdef DISPLAY_COUNTER_SCAN_EN
    chk("reset_comm", {28'h0, comm_b}, 32'hF);
    chk("reset_seg", {25'h0, seg_b}, 32'h0);
`endif

    // First tick lands on the 4th edge after enabling from reset.
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("first_tick_e%0d", k), {31'h0, tick_b}, (k == 4) ? 32'h1 : 32'h0);
    end
    chk("first_count", {16'h0, count_b}, 32'h0001);
    chk("first_count_hex", {16'h0, count_h}, 32'h0001);
    @(negedge clk);
    chk("tick_one_cycle", {31'h0, tick_b}, 32'h0);
    @(negedge clk);

    // Freeze mid-interval for 3 cycles: tick moves from 2 to 5 edges away.
    en = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        chk("freeze_count", {16'h0, count_b}, 32'h0001);
        en = 1'b1;
      end
    end while (!tick_b && n < 20);
    chk("freeze_delay", n, 5);
    chk("freeze_next_count", {16'h0, count_b}, 32'h0002);

    // Asynchronous reset between edges.
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_count", {16'h0, count_b}, 32'h0);
    chk("async_rst_count_hex", {16'h0, count_h}, 32'h0);
    chk("async_rst_tick", {31'h0, tick_b}, 32'h0);
`ifdef DISPLAY_COUNTER_SCAN_EN
    chk("async_rst_comm", {28'h0, comm_b}, 32'hF);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Load-and-step vectors through the scoreboard.
    foreach (vecs[i]) begin
      up = vecs[i].up; load = 1'b1; load_val = vecs[i].lv; en = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_load_bcd", i), {16'h0, count_b}, {16'h0, vecs[i].ld_b});
      chk($sformatf("v%0d_load_hex", i), {16'h0, count_h}, {16'h0, vecs[i].ld_h});
      chk($sformatf("v%0d_load_tick", i), {31'h0, tick_b}, 32'h0);
      sb.push_back('{vecs[i].nx_b, vecs[i].nx_h, vecs[i].tc_b, vecs[i].tc_h});
      load = 1'b0;
      wait_tick(10, n);
      chk($sformatf("v%0d_latency", i), n, 4);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk($sformatf("v%0d_count_bcd", i), {16'h0, count_b}, {16'h0, e.nx_b});
        chk($sformatf("v%0d_count_hex", i), {16'h0, count_h}, {16'h0, e.nx_h});
        chk($sformatf("v%0d_tc_bcd", i), {31'h0, tc_b}, {31'h0, e.tc_b});
        chk($sformatf("v%0d_tc_hex", i), {31'h0, tc_h}, {31'h0, e.tc_h});
        chk($sformatf("v%0d_tick_hex", i), {31'h0, tick_h}, 32'h1);
      end
      @(negedge clk);
      chk($sformatf("v%0d_tc_pulse", i), {31'h0, tc_b | tc_h}, 32'h0);
    end
    chk("scoreboard_empty", sb.size(), 0);

    // Load colliding with the tick edge wins and restarts the interval.
    up = 1'b1;
    wait_tick(10, n);
    chk("pre_collide_tick", {31'h0, tick_b}, 32'h1);
    repeat (3) @(negedge clk);
    load = 1'b1; load_val = 16'h00A5;
    @(negedge clk);
    chk("collide_count", {16'h0, count_b}, 32'h0095);
    chk("collide_count_hex", {16'h0, count_h}, 32'h00A5);
    chk("collide_tick", {31'h0, tick_b | tick_h}, 32'h0);
    load = 1'b0;
    wait_tick(10, n);
    chk("collide_latency", n, 4);
    chk("collide_next", {16'h0, count_b}, 32'h0096);

`ifdef DISPLAY_COUNTER_SCAN_EN
    // Scan sequence after reset with 0x1234 loaded on the first edge.
    @(negedge clk);
    rst = 1'b1; en = 1'b0; load = 1'b1; load_val = 16'h1234;
    #2 rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      logic [3:0] exp_comm [9];
      logic [6:0] exp_seg  [9];
      exp_comm = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011,
                   4'b0111, 4'b0111, 4'b1110};
      exp_seg  = '{7'h3F, 7'h66, 7'h4F, 7'h4F, 7'h5B, 7'h5B, 7'h06, 7'h06, 7'h66};
      @(negedge clk);
      load = 1'b0;
      chk($sformatf("scan_comm_e%0d", k), {28'h0, comm_b}, {28'h0, exp_comm[k-1]});
      if (k >= 2)
        chk($sformatf("scan_seg_e%0d", k), {25'h0, seg_b}, {25'h0, exp_seg[k-1]});
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
